reg_bank_writer: RTL and testbench
==================================

Name: reg_bank_writer

Overview:
- Write-side counterpart of the 8-way register-select read mux: owns the eight 8-bit general registers and their single write port.
- Decodes a 3-bit write address into per-register enables.
- Supports single writes, auto-incrementing burst writes and a sequenced clear-all.
- The flattened register outputs feed the read-select mux directly.

Parameters:
DATA_W, 8, register width in bits
ADDR_W, 3, address width; register count NREG = 2**ADDR_W (8)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
wr_valid  in  1  write beat offered
wr_ready  out  1  block can accept a beat this cycle
wr_addr  in  ADDR_W  target register, single write or first beat of a burst
wr_data  in  DATA_W  write data
wr_burst  in  1  sampled with the first accepted beat; 1 = start burst
wr_len  in  ADDR_W  burst beats minus 1, sampled with the first beat (0 = 1 beat, 7 = 8 beats)
clr_req  in  1  level request to clear all registers
busy  out  1  state != IDLE
dirty  out  NREG  dirty[i] = register i written since last clear/reset
reg_q  out  NREG*DATA_W  register i at bits [DATA_W*i +: DATA_W]

Behaviour:
- Reset: on a rising edge with rst_n=0:
  - reg_q=0, dirty=0, state=IDLE, ptr=0, cnt=0.
  - Reset wins over any simultaneous write or clear.
- Reset asserted mid-burst or mid-clear aborts the operation immediately; no partial completion afterwards.
- Beat acceptance: a beat is accepted when wr_valid & wr_ready at a rising edge.
  - Accepted data is written into the register at that edge and is visible on reg_q in the next cycle (1-cycle write latency).
  - The corresponding dirty bit sets at the same edge.
- wr_ready = 1 in IDLE and BURST, 0 in CLEAR. Combinational from state.
- FSM IDLE:
  - clr_req=1 -> CLEAR with ptr=0. Clear has priority: a simultaneous wr_valid is not accepted, because wr_ready drops combinationally when clr_req=1 in IDLE.
  - Accepted beat with wr_burst=0 -> write reg[wr_addr]; stay IDLE.
  - Accepted beat with wr_burst=1 -> write reg[wr_addr]. If wr_len=0, stay IDLE. Otherwise go to BURST with ptr = wr_addr+1 (mod NREG) and cnt = wr_len-1.
  - Consequently, wr_ready in IDLE = ~clr_req.
- FSM BURST:
  - wr_addr, wr_burst and wr_len are ignored.
  - Each accepted beat writes reg[ptr] and then ptr = ptr+1 (mod NREG, wraps 7->0).
  - If cnt=0 on the accepted beat -> IDLE; else cnt = cnt-1.
  - Cycles without wr_valid hold all state (stalls allowed indefinitely).
  - clr_req is ignored in BURST; the requester holds it, and it is honoured on return to IDLE.
- FSM CLEAR:
  - Each cycle writes 0 to reg[ptr] and clears dirty[ptr], then ptr = ptr+1.
  - After the edge that clears reg[NREG-1], return to IDLE.
  - Duration is exactly NREG (8) cycles with busy=1.
  - If clr_req is still high on return, a new clear starts immediately (one IDLE cycle, wr_ready=0).
- Wrap: a burst of 8 beats starting at any address writes every register exactly once. A burst of 8 beats starting at 5 writes 5,6,7,0,1,2,3,4.
- Writing a register that already holds the same value still sets its dirty bit.
- Output rules:
  - No combinational path from wr_data to reg_q.
  - busy and dirty are registered-state derived.

Test Plan:
- Reset release, then single writes 0xA5->addr 3 and 0x5A->addr 7: next cycle reg_q byte3=0xA5, byte7=0x5A, others 0; dirty=8'b1000_1000; busy=0.
- Burst wr_addr=6, wr_len=3, data 0x11,0x22,0x33,0x44 with a 2-cycle wr_valid gap after the second beat: regs 6,7,0,1 = 0x11,0x22,0x33,0x44; busy=1 from after the first beat until after the fourth; wr_ready stays 1 throughout.
- With all registers dirty, pulse clr_req (held 1 cycle) in IDLE together with wr_valid=1 addr 2 data 0xFF: write not accepted (wr_ready=0); 8 cycles busy with wr_ready=0; afterwards reg_q=0 and dirty=0.
- clr_req asserted during a burst with 2 beats remaining: the burst completes normally, then CLEAR starts the cycle after return to IDLE; final reg_q=0.
- rst_n=0 for one edge at cycle 4 of CLEAR (and separately mid-burst): state IDLE, all registers 0, dirty 0 in the next cycle; a subsequent write 0x3C->addr 0 succeeds with normal 1-cycle latency.

Source files
------------

// File: rtl/reg_bank_writer.sv
// rtl/reg_bank_writer.sv - eight-register bank with single, burst and sequenced clear-all writes
module reg_bank_writer #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           wr_valid,
   output logic                           wr_ready,
   input  logic [ADDR_W-1:0]              wr_addr,
   input  logic [DATA_W-1:0]              wr_data,
   input  logic                           wr_burst,
   input  logic [ADDR_W-1:0]              wr_len,
   input  logic                           clr_req,
   output logic                           busy,
   output logic [(2**ADDR_W)-1:0]         dirty,
   output logic [(2**ADDR_W)*DATA_W-1:0]  reg_q
);

   localparam int NREG = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      CLEAR = 2'd2
   } state_t;

   state_t                          state_q, state_d;
   logic [ADDR_W-1:0]               ptr_q, ptr_d;
   logic [ADDR_W-1:0]               cnt_q, cnt_d;
   logic [NREG-1:0][DATA_W-1:0]     regs_q, regs_d;
   logic [NREG-1:0]                 dirty_q, dirty_d;

   // In IDLE a pending clear steals the write port, so ready drops with clr_req.
   always_comb begin
      wr_ready = 1'b0;
      case (state_q)
         IDLE:    wr_ready = ~clr_req;
         BURST:   wr_ready = 1'b1;
         default: wr_ready = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      regs_d  = regs_q;
      dirty_d = dirty_q;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end else if (wr_valid) begin
               regs_d[wr_addr]  = wr_data;
               dirty_d[wr_addr] = 1'b1;
               if (wr_burst && (wr_len != '0)) begin
                  state_d = BURST;
                  ptr_d   = wr_addr + 1'b1;
                  cnt_d   = wr_len - 1'b1;
               end
            end
         end
         BURST: begin
            if (wr_valid) begin
               regs_d[ptr_q]  = wr_data;
               dirty_d[ptr_q] = 1'b1;
               ptr_d          = ptr_q + 1'b1;
               if (cnt_q == '0) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         CLEAR: begin
            regs_d[ptr_q]  = '0;
            dirty_d[ptr_q] = 1'b0;
            ptr_d          = ptr_q + 1'b1;
            if (ptr_q == ADDR_W'(NREG - 1)) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         regs_q  <= '0;
         dirty_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         regs_q  <= regs_d;
         dirty_q <= dirty_d;
      end
   end

   assign busy  = (state_q != IDLE);
   assign dirty = dirty_q;
   assign reg_q = regs_q;

endmodule

// File: tb/tb_reg_bank_writer.sv
// tb/tb_reg_bank_writer.sv - directed and randomized checks of reg_bank_writer against a register-array model
module tb_reg_bank_writer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_valid;
   logic        wr_ready;
   logic [2:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        wr_burst;
   logic [2:0]  wr_len;
   logic        clr_req;
   logic        busy;
   logic [7:0]  dirty;
   logic [63:0] reg_q;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] m_reg [8];
   bit         m_dirty [8];

   reg_bank_writer #(.DATA_W(8), .ADDR_W(3)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_burst (wr_burst),
      .wr_len   (wr_len),
      .clr_req  (clr_req),
      .busy     (busy),
      .dirty    (dirty),
      .reg_q    (reg_q)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish (obs=timeout exp=finish)");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] pack_regs();
      logic [63:0] v;
      for (int i = 0; i < 8; i++) v[8*i +: 8] = m_reg[i];
      return v;
   endfunction

   function automatic logic [63:0] pack_dirty();
      logic [63:0] v = '0;
      for (int i = 0; i < 8; i++) v[i] = m_dirty[i];
      return v;
   endfunction

   task automatic model_write(input int a, input logic [7:0] d);
      m_reg[a % 8]   = d;
      m_dirty[a % 8] = 1'b1;
   endtask

   task automatic model_zero();
      for (int i = 0; i < 8; i++) begin
         m_reg[i]   = 8'h00;
         m_dirty[i] = 1'b0;
      end
   endtask

   task automatic chk_bank(input string tag);
      chk({tag, ".reg_q"}, reg_q, pack_regs());
      chk({tag, ".dirty"}, {56'd0, dirty}, pack_dirty());
   endtask

   task automatic idle_inputs();
      wr_valid = 1'b0;
      wr_burst = 1'b0;
      wr_addr  = 3'd0;
      wr_len   = 3'd0;
      wr_data  = 8'h00;
   endtask

   task automatic do_single(input int a, input logic [7:0] d);
      wr_valid = 1'b1;
      wr_burst = 1'b0;
      wr_addr  = 3'(a);
      wr_len   = 3'($urandom_range(0, 7));
      wr_data  = d;
      #1;
      chk("single.ready", {63'd0, wr_ready}, 64'd1);
      tick();
      model_write(a, d);
      idle_inputs();
      chk("single.busy", {63'd0, busy}, 64'd0);
   endtask

   // Beats land at consecutive addresses modulo 8; gaps of gap_n idle cycles precede beat gap_at.
   task automatic do_burst(input int a, input int len, input logic [63:0] dat,
                           input int gap_at, input int gap_n, input int clr_at);
      for (int k = 0; k <= len; k++) begin
         if (k == clr_at) clr_req = 1'b1;
         if (k == gap_at) begin
            for (int g = 0; g < gap_n; g++) begin
               wr_valid = 1'b0;
               tick();
               if (k > 0) chk("burst.stall_busy", {63'd0, busy}, 64'd1);
            end
         end
         wr_valid = 1'b1;
         wr_data  = dat[8*k +: 8];
         wr_addr  = (k == 0) ? 3'(a) : 3'($urandom_range(0, 7));
         wr_burst = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         wr_len   = (k == 0) ? 3'(len) : 3'($urandom_range(0, 7));
         #1;
         chk("burst.ready", {63'd0, wr_ready}, 64'd1);
         tick();
         model_write(a + k, dat[8*k +: 8]);
         chk("burst.busy", {63'd0, busy}, (k < len) ? 64'd1 : 64'd0);
      end
      idle_inputs();
   endtask

   task automatic do_clear(input bit with_write);
      clr_req = 1'b1;
      if (with_write) begin
         wr_valid = 1'b1;
         wr_addr  = 3'd2;
         wr_data  = 8'hFF;
         wr_burst = 1'b0;
      end
      #1;
      chk("clear.ready_on_req", {63'd0, wr_ready}, 64'd0);
      tick();
      clr_req = 1'b0;
      idle_inputs();
      for (int i = 0; i < 8; i++) begin
         chk("clear.busy", {63'd0, busy}, 64'd1);
         chk("clear.ready", {63'd0, wr_ready}, 64'd0);
         tick();
      end
      model_zero();
      chk("clear.done_busy", {63'd0, busy}, 64'd0);
      chk("clear.done_ready", {63'd0, wr_ready}, 64'd1);
      chk_bank("clear.done");
   endtask

   initial begin
      int op;
      logic [63:0] rd;
      rst_n   = 1'b0;
      clr_req = 1'b0;
      idle_inputs();
      model_zero();
      tick();
      tick();
      rst_n = 1'b1;
      chk_bank("reset");
      chk("reset.busy", {63'd0, busy}, 64'd0);
      chk("reset.ready", {63'd0, wr_ready}, 64'd1);

      do_single(3, 8'hA5);
      do_single(7, 8'h5A);
      chk_bank("single_pair");

      do_burst(6, 3, 64'h44_33_22_11, 2, 2, -1);
      chk_bank("burst_wrap_gap");

      do_burst(5, 7, {$urandom, $urandom}, -1, 0, -1);
      chk_bank("burst8_from5");
      chk("burst8.all_dirty", {56'd0, dirty}, 64'hFF);

      do_single(4, m_reg[4]);
      do_clear(1'b1);
      do_single(1, 8'h77);
      chk("after_clear.dirty", {56'd0, dirty}, 64'h02);

      // Clear requested with two beats left: burst finishes, then clear starts.
      do_burst(0, 4, 64'h00_55_44_33_22_11, -1, 0, 3);
      chk_bank("burst_before_clear");
      chk("pending_clear.ready", {63'd0, wr_ready}, 64'd0);
      do_clear(1'b0);

      for (int i = 0; i < 8; i++) do_single(i, 8'(8'h80 + i));
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      model_zero();
      chk("rst_mid_clear.busy", {63'd0, busy}, 64'd0);
      chk_bank("rst_mid_clear");
      do_single(0, 8'h3C);
      chk_bank("rst_mid_clear.write");

      wr_valid = 1'b1; wr_burst = 1'b1; wr_addr = 3'd2; wr_len = 3'd5; wr_data = 8'hC1;
      tick();
      wr_data = 8'hC2;
      tick();
      wr_data = 8'hEE;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      idle_inputs();
      model_zero();
      chk("rst_mid_burst.busy", {63'd0, busy}, 64'd0);
      chk_bank("rst_mid_burst");
      do_single(4, 8'h3C);
      chk_bank("rst_mid_burst.write");

      for (int n = 0; n < 40; n++) begin
         op = $urandom_range(0, 9);
         if (op == 0) begin
            do_clear(1'($urandom_range(0, 1)));
         end else if (op < 5) begin
            do_single($urandom_range(0, 7), 8'($urandom));
            chk_bank("rand.single");
         end else begin
            rd = {$urandom, $urandom};
            do_burst($urandom_range(0, 7), $urandom_range(0, 7), rd,
                     $urandom_range(0, 7), $urandom_range(0, 3), -1);
            chk_bank("rand.burst");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
